// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues req/ack fetches to instruction memory,
// holds a fetched word across pipeline stalls and redirects on taken branches.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        MemStall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] instr_o,
    output logic [31:0] PC_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] addr_q, addr_d;
    logic        advance;

    assign advance = ~stall_i & ~MemStall_i;

    // Request and address depend on registered state only, never on imem_ack_i.
    assign imem_req_o  = (state_q == S_REQ) || (state_q == S_DRAIN);
    assign imem_addr_o = (state_q == S_DRAIN) ? addr_q : pc_q;

    always_comb begin
        instr_o = 32'h0;
        PC_o    = 32'h0;
        if (!branch_i) begin
            if (state_q == S_REQ && imem_ack_i) begin
                instr_o = imem_data_i;
                PC_o    = pc_q;
            end else if (state_q == S_HOLD) begin
                instr_o = hold_q;
                PC_o    = pc_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        addr_d  = addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (branch_i)     pc_d    = branch_target_i;
                else if (start_i) state_d = S_REQ;
            end
            S_REQ: begin
                if (branch_i) begin
                    pc_d = branch_target_i;
                    if (!imem_ack_i) begin
                        // keep presenting the abandoned address until memory answers
                        addr_d  = pc_q;
                        state_d = S_DRAIN;
                    end
                end else if (imem_ack_i) begin
                    if (advance) begin
                        pc_d = pc_q + 32'd4;
                    end else begin
                        hold_d  = imem_data_i;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (branch_i) begin
                    pc_d    = branch_target_i;
                    state_d = S_REQ;
                end else if (advance) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (branch_i)        pc_d    = branch_target_i;
                else if (imem_ack_i) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            hold_q  <= 32'h0;
            addr_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            addr_q  <= addr_d;
        end
    end

endmodule
